// File: rtl/paddle_collision_unit_if.sv
// Signal bundle between GameFSM / renderer side and the paddle collision unit.
// The master modport is the game side (buttons, ball state, game state);
// the slave modport is the collision unit itself.
interface paddle_collision_unit_if;
  logic       button0;
  logic       button1;
  logic       button2;
  logic       button3;
  logic [9:0] ballX;
  logic [8:0] ballY;
  logic [5:0] paddlewidth;
  logic [3:0] gamestate;
  logic [8:0] paddle1Y;
  logic [8:0] paddle2Y;
  logic       coll_L;
  logic       coll_T;
  logic       coll_R;
  logic       coll_B;
  logic       outofbounds;
  logic [1:0] whoscored;

  modport master (
    output button0, button1, button2, button3,
    output ballX, ballY, paddlewidth, gamestate,
    input  paddle1Y, paddle2Y,
    input  coll_L, coll_T, coll_R, coll_B,
    input  outofbounds, whoscored
  );

  modport slave (
    input  button0, button1, button2, button3,
    input  ballX, ballY, paddlewidth, gamestate,
    output paddle1Y, paddle2Y,
    output coll_L, coll_T, coll_R, coll_B,
    output outofbounds, whoscored
  );
endinterface

// File: rtl/paddle_collision_unit.sv
// Paddle position tracking and ball collision / scoring detection.
// Paddles move by PADDLE_STEP once every PADDLE_DIV cycles under button
// control; collision flags are registered each cycle; a small FSM raises
// outofbounds for exactly OOB_HOLD cycles per score and re-arms only after
// the game has gone back to IDLE.
module paddle_collision_unit #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_X1    = 16,
  parameter int PADDLE_X2    = 616,
  parameter int PADDLE_THICK = 8,
  parameter int PADDLE_DIV   = 250000,
  parameter int PADDLE_STEP  = 2,
  parameter int OOB_HOLD     = 30000000
) (
  input logic                    clk,
  input logic                    reset,
  paddle_collision_unit_if.slave bus
);

  localparam int DIV_W  = (PADDLE_DIV > 1) ? $clog2(PADDLE_DIV) : 1;
  localparam int HOLD_W = (OOB_HOLD > 1) ? $clog2(OOB_HOLD) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(PADDLE_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(OOB_HOLD - 1);

  localparam logic [9:0]  STEP10   = 10'(PADDLE_STEP);
  localparam logic [9:0]  SCR_H10  = 10'(SCREEN_H);
  localparam logic [8:0]  PAD_INIT = 9'd220;

  localparam logic [10:0] BS11     = 11'(BALL_SIZE);
  localparam logic [10:0] BOT_LIM  = 11'(SCREEN_H - 1);
  localparam logic [10:0] X1_11    = 11'(PADDLE_X1);
  localparam logic [10:0] X1_FAR   = 11'(PADDLE_X1 + PADDLE_THICK);
  localparam logic [10:0] X2_11    = 11'(PADDLE_X2);
  localparam logic [10:0] X2_FAR   = 11'(PADDLE_X2 + PADDLE_THICK);

  localparam logic [9:0]  LEFT_LIM  = 10'd3;
  localparam logic [9:0]  WRAP_LIM  = 10'(SCREEN_W);
  localparam logic [9:0]  RIGHT_LIM = 10'(SCREEN_W - BALL_SIZE - 4);

  localparam logic [1:0] ST_ARMED = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // Next paddle position for one tick: step, floor at 0, ceiling at
  // SCREEN_H - paddlewidth. The ceiling is applied even with no button so a
  // shrinking paddle pulls the paddle back on screen.
  function automatic logic [8:0] paddle_next(input logic [8:0] y,
                                             input logic       up,
                                             input logic       dn,
                                             input logic [5:0] pw);
    logic [9:0] y10;
    logic [9:0] ceil10;
    logic [9:0] cand;
    y10    = {1'b0, y};
    ceil10 = SCR_H10 - {4'd0, pw};
    if (up && !dn) begin
      if (y10 >= STEP10) begin
        cand = y10 - STEP10;
      end else begin
        cand = 10'd0;
      end
    end else if (dn && !up) begin
      cand = y10 + STEP10;
    end else begin
      cand = y10;
    end
    if (cand > ceil10) begin
      cand = ceil10;
    end
    return 9'(cand);
  endfunction

  logic [DIV_W-1:0]  tick_q;
  logic              tick_s;
  logic [8:0]        paddle1_q, paddle1_d;
  logic [8:0]        paddle2_q, paddle2_d;
  logic              coll_l_q, coll_l_d;
  logic              coll_t_q, coll_t_d;
  logic              coll_r_q, coll_r_d;
  logic              coll_b_q, coll_b_d;
  logic [1:0]        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              oob_q, oob_d;
  logic [1:0]        who_q, who_d;

  logic              active_s;
  logic              left_exit_s;
  logic              right_exit_s;
  logic [10:0]       bx11_s;
  logic [10:0]       by11_s;
  logic [10:0]       pw11_s;
  logic [10:0]       p1_11_s;
  logic [10:0]       p2_11_s;

  assign tick_s       = (tick_q == DIV_LAST);
  assign active_s     = (bus.gamestate != 4'd0);
  assign left_exit_s  = (bus.ballX <= LEFT_LIM) || (bus.ballX >= WRAP_LIM);
  assign right_exit_s = (bus.ballX >= RIGHT_LIM);

  assign bx11_s  = {1'b0, bus.ballX};
  assign by11_s  = {2'b00, bus.ballY};
  assign pw11_s  = {5'd0, bus.paddlewidth};
  assign p1_11_s = {2'b00, paddle1_q};
  assign p2_11_s = {2'b00, paddle2_q};

  // Free-running paddle tick divider, wraps after PADDLE_DIV-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_q <= {DIV_W{1'b0}};
    end else if (tick_s) begin
      tick_q <= {DIV_W{1'b0}};
    end else begin
      tick_q <= tick_q + DIV_W'(1);
    end
  end

  // Paddle next-state: only moves in the tick cycle.
  always_comb begin
    paddle1_d = paddle1_q;
    paddle2_d = paddle2_q;
    if (tick_s) begin
      paddle1_d = paddle_next(paddle1_q, bus.button0, bus.button1, bus.paddlewidth);
      paddle2_d = paddle_next(paddle2_q, bus.button2, bus.button3, bus.paddlewidth);
    end else begin
      paddle1_d = paddle1_q;
      paddle2_d = paddle2_q;
    end
  end

  // Paddle position registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      paddle1_q <= PAD_INIT;
      paddle2_q <= PAD_INIT;
    end else begin
      paddle1_q <= paddle1_d;
      paddle2_q <= paddle2_d;
    end
  end

  // Collision flag next-state; everything suppressed while the game is idle.
  always_comb begin
    coll_l_d = 1'b0;
    coll_t_d = 1'b0;
    coll_r_d = 1'b0;
    coll_b_d = 1'b0;
    if (active_s) begin
      coll_t_d = (by11_s <= 11'd1);
      coll_b_d = (by11_s + BS11 >= BOT_LIM);
      coll_l_d = (bx11_s <= X1_FAR) && (bx11_s + BS11 > X1_11) &&
                 (by11_s + BS11 > p1_11_s) && (by11_s < p1_11_s + pw11_s);
      coll_r_d = (bx11_s + BS11 >= X2_11) && (bx11_s < X2_FAR) &&
                 (by11_s + BS11 > p2_11_s) && (by11_s < p2_11_s + pw11_s);
    end else begin
      coll_l_d = 1'b0;
      coll_t_d = 1'b0;
      coll_r_d = 1'b0;
      coll_b_d = 1'b0;
    end
  end

  // Collision flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coll_l_q <= 1'b0;
      coll_t_q <= 1'b0;
      coll_r_q <= 1'b0;
      coll_b_q <= 1'b0;
    end else begin
      coll_l_q <= coll_l_d;
      coll_t_q <= coll_t_d;
      coll_r_q <= coll_r_d;
      coll_b_q <= coll_b_d;
    end
  end

  // Score FSM next-state: detect exit, hold outofbounds, wait for IDLE.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    oob_d   = oob_q;
    who_d   = who_q;
    case (state_q)
      ST_ARMED: begin
        if (active_s && left_exit_s) begin
          who_d   = 2'b10;
          oob_d   = 1'b1;
          hold_d  = HOLD_LOAD;
          state_d = ST_HOLD;
        end else if (active_s && right_exit_s) begin
          who_d   = 2'b01;
          oob_d   = 1'b1;
          hold_d  = HOLD_LOAD;
          state_d = ST_HOLD;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_HOLD: begin
        if (hold_q == {HOLD_W{1'b0}}) begin
          oob_d   = 1'b0;
          state_d = ST_WAIT;
        end else begin
          hold_d  = hold_q - HOLD_W'(1);
        end
      end
      ST_WAIT: begin
        if (!active_s) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        oob_d   = 1'b0;
        state_d = ST_ARMED;
      end
    endcase
  end

  // Score FSM registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_ARMED;
      hold_q  <= {HOLD_W{1'b0}};
      oob_q   <= 1'b0;
      who_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      oob_q   <= oob_d;
      who_q   <= who_d;
    end
  end

  assign bus.paddle1Y    = paddle1_q;
  assign bus.paddle2Y    = paddle2_q;
  assign bus.coll_L      = coll_l_q;
  assign bus.coll_T      = coll_t_q;
  assign bus.coll_R      = coll_r_q;
  assign bus.coll_B      = coll_b_q;
  assign bus.outofbounds = oob_q;
  assign bus.whoscored   = who_q;

endmodule

// File: tb/tb_paddle_collision_unit.sv
// Directed bench for paddle_collision_unit with a short tick divider and a
// short outofbounds hold so every behaviour fits in a few thousand cycles.
module tb_paddle_collision_unit;

  localparam int TB_DIV  = 4;
  localparam int TB_HOLD = 10;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  paddle_collision_unit_if bus_if ();

  paddle_collision_unit #(
    .PADDLE_DIV (TB_DIV),
    .OOB_HOLD   (TB_HOLD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts and reports mismatches.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n clocks and land 1 time unit after the last rising edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_buttons(input logic b0, input logic b1, input logic b2, input logic b3);
    bus_if.button0 = b0;
    bus_if.button1 = b1;
    bus_if.button2 = b2;
    bus_if.button3 = b3;
  endtask

  initial begin
    int hi_cnt;
    bit done;
    n_cmp = 0;
    n_err = 0;
    set_buttons(1'b0, 1'b0, 1'b0, 1'b0);
    bus_if.ballX       = 10'd320;
    bus_if.ballY       = 9'd200;
    bus_if.paddlewidth = 6'd40;
    bus_if.gamestate   = 4'd0;
    reset = 1'b1;
    #2 reset = 1'b0;
    cycles(3);

    // Reset state
    check_val("rst_p1", bus_if.paddle1Y, 220);
    check_val("rst_p2", bus_if.paddle2Y, 220);
    check_val("rst_flags", {bus_if.coll_L, bus_if.coll_T, bus_if.coll_R, bus_if.coll_B}, 0);
    check_val("rst_oob", bus_if.outofbounds, 0);
    check_val("rst_who", bus_if.whoscored, 0);
    reset = 1'b1;
    cycles(10);
    check_val("idle_p1", bus_if.paddle1Y, 220);
    check_val("idle_p2", bus_if.paddle2Y, 220);

    // Top / bottom walls suppressed while IDLE
    bus_if.ballY = 9'd1;
    cycles(1);
    check_val("idle_T", bus_if.coll_T, 0);
    bus_if.ballY = 9'd471;
    cycles(1);
    check_val("idle_B", bus_if.coll_B, 0);

    // Walls while playing, including edges of each threshold
    bus_if.gamestate = 4'd1;
    bus_if.ballY = 9'd1;
    cycles(1);
    check_val("T_y1", bus_if.coll_T, 1);
    bus_if.ballY = 9'd2;
    cycles(1);
    check_val("T_y2", bus_if.coll_T, 0);
    bus_if.ballY = 9'd471;
    cycles(1);
    check_val("B_y471", bus_if.coll_B, 1);
    bus_if.ballY = 9'd470;
    cycles(1);
    check_val("B_y470", bus_if.coll_B, 0);

    // Left paddle at 220, length 40
    bus_if.ballX = 10'd24;
    bus_if.ballY = 9'd215;
    cycles(1);
    check_val("L_hit", bus_if.coll_L, 1);
    bus_if.ballY = 9'd211;
    cycles(1);
    check_val("L_above", bus_if.coll_L, 0);
    bus_if.ballY = 9'd215;
    bus_if.ballX = 10'd25;
    cycles(1);
    check_val("L_x25", bus_if.coll_L, 0);
    bus_if.ballX = 10'd320;
    bus_if.gamestate = 4'd0;

    // Bring paddle 2 up to 100
    set_buttons(1'b0, 1'b0, 1'b1, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      cycles(1);
      if (bus_if.paddle2Y == 9'd100) begin
        set_buttons(1'b0, 1'b0, 1'b0, 1'b0);
        done = 1'b1;
      end
    end
    cycles(12);
    check_val("p2_at100", bus_if.paddle2Y, 100);
    check_val("p1_still", bus_if.paddle1Y, 220);

    // Right paddle collision and bottom-edge boundary of the paddle
    bus_if.gamestate = 4'd1;
    bus_if.ballX = 10'd608;
    bus_if.ballY = 9'd139;
    cycles(1);
    check_val("R_hit", bus_if.coll_R, 1);
    bus_if.ballY = 9'd140;
    cycles(1);
    check_val("R_below", bus_if.coll_R, 0);
    bus_if.ballX = 10'd320;
    bus_if.gamestate = 4'd0;
    cycles(1);

    // Paddle 1 down for 200 ticks saturates at 480-40
    set_buttons(1'b0, 1'b1, 1'b0, 1'b0);
    cycles(200 * TB_DIV);
    check_val("p1_ceil", bus_if.paddle1Y, 440);
    set_buttons(1'b1, 1'b1, 1'b0, 1'b0);
    cycles(5 * TB_DIV);
    check_val("p1_both", bus_if.paddle1Y, 440);

    // Paddle shrink / grow against the ceiling
    bus_if.paddlewidth = 6'd38;
    set_buttons(1'b0, 1'b1, 1'b0, 1'b0);
    cycles(2 * TB_DIV);
    check_val("p1_w38", bus_if.paddle1Y, 442);
    cycles(3 * TB_DIV);
    check_val("p1_w38_hold", bus_if.paddle1Y, 442);
    set_buttons(1'b0, 1'b0, 1'b0, 1'b0);
    bus_if.paddlewidth = 6'd40;
    cycles(2 * TB_DIV);
    check_val("p1_clamp", bus_if.paddle1Y, 440);

    // Paddle 1 up to the floor
    set_buttons(1'b1, 1'b0, 1'b0, 1'b0);
    cycles(250 * TB_DIV);
    check_val("p1_floor", bus_if.paddle1Y, 0);
    check_val("p2_unmoved", bus_if.paddle2Y, 100);
    set_buttons(1'b0, 1'b0, 1'b0, 1'b0);

    // Left exit through wrap: player 2 scores, hold TB_HOLD cycles
    bus_if.gamestate = 4'd2;
    bus_if.ballX = 10'd1022;
    cycles(1);
    check_val("oob_rise", bus_if.outofbounds, 1);
    check_val("who_left", bus_if.whoscored, 2);
    hi_cnt = 1;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (hi_cnt == 3) bus_if.ballX = 10'd630;
      cycles(1);
      if (bus_if.outofbounds) hi_cnt++;
      else done = 1'b1;
    end
    check_val("oob_len", hi_cnt, TB_HOLD);
    cycles(5);
    check_val("second_oob", bus_if.outofbounds, 0);
    check_val("second_who", bus_if.whoscored, 2);

    // Back to IDLE re-arms, right exit scores for player 1
    bus_if.gamestate = 4'd0;
    cycles(1);
    bus_if.gamestate = 4'd2;
    cycles(1);
    check_val("oob_right", bus_if.outofbounds, 1);
    check_val("who_right", bus_if.whoscored, 1);

    // Reset mid-hold drops outofbounds asynchronously
    cycles(3);
    #2 reset = 1'b0;
    #1;
    check_val("rst_mid_oob", bus_if.outofbounds, 0);
    check_val("rst_mid_who", bus_if.whoscored, 0);
    check_val("rst_mid_p1", bus_if.paddle1Y, 220);
    bus_if.gamestate = 4'd0;
    bus_if.ballX = 10'd320;
    cycles(2);
    reset = 1'b1;
    cycles(2);
    check_val("post_rst_oob", bus_if.outofbounds, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
